l2_coherence_requester: RTL and testbench
=========================================

Name: l2_coherence_requester

Overview:
- L2-side initiator of the MESI coherence handshake with the central arbiter; one instance per L2 cache (L2a–L2d).
- Accepts one coherence request (read-update or write-update) from the L2 controller and drives the arbiter request lines, address and local block data.
- Waits for arbiter_verify, captures mesi_state_to_cache, acknowledges, then returns the state to the L2 controller.
- Adds timeout/retry and statistics counters.

Parameters:
- TIMEOUT_CYCLES, 16: cycles in REQ without arbiter_verify before the request is withdrawn and retried.
- MAX_RETRIES, 3: retries before the request completes with error.
- CNT_WIDTH, 16: width of the statistics counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  L2 controller request strobe.
- req_is_write  in  1  1 = write-update, 0 = read-update.
- req_address  in  ADDRESS_WIDTH  block address.
- req_data  in  MAIN_MEMORY_DATA_WIDTH  local copy of block data.
- req_ready  out  1  high only in IDLE.
- block_to_determine_mesi_state_from_arbiter  out  ADDRESS_WIDTH  latched address to arbiter.
- l2_local_data  out  MAIN_MEMORY_DATA_WIDTH  latched data to arbiter.
- arbiter_read_update_from_L2_cache_modules  out  1  read-update request level.
- arbiter_write_update_from_L2_cache_modules  out  1  write-update request level.
- acknowledge_arbiter_verify  out  1  acknowledge level.
- mesi_state_to_cache  in  MESI_STATE_WIDTH  state from arbiter.
- arbiter_verify  in  1  arbiter response valid (level).
- resp_valid  out  1  one-cycle completion pulse.
- resp_mesi_state  out  MESI_STATE_WIDTH  captured state (MESI_INVALID on error).
- resp_error  out  1  qualifies resp_valid; retries exhausted.
- stat_requests, stat_retries, stat_errors  out  CNT_WIDTH each  saturating counters.

Behaviour:
- Reset (synchronous): state IDLE. All outputs 0. Latches, timeout counter, retry counter and stats cleared. Reset in any state aborts the transaction on the next edge with no resp_valid. Request and ack lines are 0 in the following cycle.
- IDLE: req_ready=1. When req_valid=1, latch address, data and is_write; go REQ; stat_requests++ (saturates at all-ones).
- REQ: assert exactly one update line, selected by the latched is_write; address and data held stable.
  - arbiter_verify=1 sampled: capture mesi_state_to_cache, go ACK.
  - Else timeout counter++. On reaching TIMEOUT_CYCLES-1: go GAP, retry++, stat_retries++.
- GAP (1 cycle): both update lines 0 so the arbiter's first-interaction latch can clear.
  - If retry == MAX_RETRIES: go RESP with error; stat_errors++.
  - Else go REQ with the timeout counter cleared.
- ACK: update lines 0; acknowledge_arbiter_verify=1. Stay while arbiter_verify=1 (minimum 1 cycle); go RESP when arbiter_verify=0.
- RESP: resp_valid=1 for one cycle with resp_mesi_state/resp_error, then IDLE. Retry counter cleared on entering IDLE.
- Read and write update lines are never both 1. The ack line is never 1 together with an update line.
- req_valid outside IDLE is ignored (req_ready=0). Back-to-back requests: minimum 1 IDLE cycle between transactions.
- Latency for a combinational arbiter: REQ→ACK→RESP, so resp_valid arrives 3 cycles after the req_valid edge.
- arbiter_verify=1 during GAP is ignored.

Decomposition:
- cache_config package: mesi_state_t enum (MESI_INVALID=0, MESI_SHARED=1, MESI_EXCLUSIVE=2, MESI_MODIFIED=3), moved there so arbiter and requester share it. Also requester_state_t (IDLE, REQ, GAP, ACK, RESP).
- ADDRESS_WIDTH, MESI_STATE_WIDTH and MAIN_MEMORY_DATA_WIDTH come from the existing packages.
- One sub-module: sat_counter (parameterised width, inc, clear), instantiated for the three stats.

Test Plan:
- Read, arbiter returns EXCLUSIVE: req_valid, is_write=0, addr=0x1A4. Response model raises verify with state=2 in the same cycle → read line high for 1 cycle, ack for 1 cycle, resp_valid with state=2 at cycle 3, stat_requests=1.
- Write: is_write=1, data=0xDEADBEEF → write line only, l2_local_data=0xDEADBEEF held through REQ, resp state=3 (MODIFIED).
- Verify held high 3 cycles after ack → ack stays high 3 cycles, resp_valid only after verify falls, exactly one pulse.
- Arbiter silent, TIMEOUT_CYCLES=4, MAX_RETRIES=2 → update line drops for one GAP cycle twice, then resp_valid with resp_error=1 and state=0; stat_retries=2, stat_errors=1.
- Reset asserted mid-ACK → next cycle all outputs 0, no resp_valid, req_ready=1 after reset.
- req_valid held high continuously → new transaction only after RESP plus 1 IDLE cycle; update lines never overlap ack (assertion).

Source files
------------

// File: rtl/cache_config.sv
// Shared cache-coherence types and widths for the L2 requesters
// and the central arbiter.
package cache_config;

    localparam int ADDRESS_WIDTH          = 32;
    localparam int MAIN_MEMORY_DATA_WIDTH = 32;
    localparam int MESI_STATE_WIDTH       = 2;

    typedef enum logic [MESI_STATE_WIDTH-1:0] {
        MESI_INVALID   = 2'd0,
        MESI_SHARED    = 2'd1,
        MESI_EXCLUSIVE = 2'd2,
        MESI_MODIFIED  = 2'd3
    } mesi_state_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        GAP,
        ACK,
        RESP
    } requester_state_t;

endpackage

// File: rtl/l2_coherence_requester_if.sv
// L2 controller request/response and arbiter coherence signals
// of one L2 coherence requester.
interface l2_coherence_requester_if;
    import cache_config::*;

    logic                              req_valid;
    logic                              req_is_write;
    logic [ADDRESS_WIDTH-1:0]          req_address;
    logic [MAIN_MEMORY_DATA_WIDTH-1:0] req_data;
    logic                              req_ready;
    logic [ADDRESS_WIDTH-1:0]          block_to_determine_mesi_state_from_arbiter;
    logic [MAIN_MEMORY_DATA_WIDTH-1:0] l2_local_data;
    logic                              arbiter_read_update_from_L2_cache_modules;
    logic                              arbiter_write_update_from_L2_cache_modules;
    logic                              acknowledge_arbiter_verify;
    logic [MESI_STATE_WIDTH-1:0]       mesi_state_to_cache;
    logic                              arbiter_verify;
    logic                              resp_valid;
    logic [MESI_STATE_WIDTH-1:0]       resp_mesi_state;
    logic                              resp_error;

    modport master (
        input  req_valid, req_is_write, req_address, req_data,
        input  mesi_state_to_cache, arbiter_verify,
        output req_ready,
        output block_to_determine_mesi_state_from_arbiter, l2_local_data,
        output arbiter_read_update_from_L2_cache_modules,
        output arbiter_write_update_from_L2_cache_modules,
        output acknowledge_arbiter_verify,
        output resp_valid, resp_mesi_state, resp_error
    );

    modport slave (
        output req_valid, req_is_write, req_address, req_data,
        output mesi_state_to_cache, arbiter_verify,
        input  req_ready,
        input  block_to_determine_mesi_state_from_arbiter, l2_local_data,
        input  arbiter_read_update_from_L2_cache_modules,
        input  arbiter_write_update_from_L2_cache_modules,
        input  acknowledge_arbiter_verify,
        input  resp_valid, resp_mesi_state, resp_error
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (clear_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/l2_coherence_requester.sv
// L2-side MESI requester: issues one update to the arbiter, waits for
// verify, acknowledges, and returns the granted state with timeout/retry.
module l2_coherence_requester
    import cache_config::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int MAX_RETRIES    = 3,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    l2_coherence_requester_if.master bus,
    output logic [CNT_WIDTH-1:0]     stat_requests,
    output logic [CNT_WIDTH-1:0]     stat_retries,
    output logic [CNT_WIDTH-1:0]     stat_errors
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    requester_state_t                  state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]          addr_q, addr_d;
    logic [MAIN_MEMORY_DATA_WIDTH-1:0] data_q, data_d;
    logic                              wr_q, wr_d;
    mesi_state_t                       mesi_q, mesi_d;
    logic                              err_q, err_d;
    logic [TW-1:0]                     tmo_q, tmo_d;
    logic [RW-1:0]                     rty_q, rty_d;
    logic                              inc_req, inc_rty, inc_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            mesi_q  <= MESI_INVALID;
            err_q   <= 1'b0;
            tmo_q   <= '0;
            rty_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            mesi_q  <= mesi_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            rty_q   <= rty_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = wr_q;
        mesi_d  = mesi_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        rty_d   = rty_q;
        inc_req = 1'b0;
        inc_rty = 1'b0;
        inc_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_address;
                    data_d  = bus.req_data;
                    wr_d    = bus.req_is_write;
                    mesi_d  = MESI_INVALID;
                    err_d   = 1'b0;
                    tmo_d   = '0;
                    inc_req = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.arbiter_verify) begin
                    mesi_d  = mesi_state_t'(bus.mesi_state_to_cache);
                    state_d = ACK;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    rty_d   = rty_q + 1'b1;
                    inc_rty = 1'b1;
                    state_d = GAP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            // Update lines low here so the arbiter can re-arm before a retry.
            GAP: begin
                if (rty_q == RW'(MAX_RETRIES)) begin
                    err_d   = 1'b1;
                    mesi_d  = MESI_INVALID;
                    inc_err = 1'b1;
                    state_d = RESP;
                end else begin
                    tmo_d   = '0;
                    state_d = REQ;
                end
            end
            ACK: begin
                if (!bus.arbiter_verify)
                    state_d = RESP;
            end
            RESP: begin
                rty_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.block_to_determine_mesi_state_from_arbiter = addr_q;
    assign bus.l2_local_data = data_q;
    assign bus.arbiter_read_update_from_L2_cache_modules  = (state_q == REQ) && !wr_q;
    assign bus.arbiter_write_update_from_L2_cache_modules = (state_q == REQ) && wr_q;
    assign bus.acknowledge_arbiter_verify = (state_q == ACK);
    assign bus.resp_valid      = (state_q == RESP);
    assign bus.resp_error      = (state_q == RESP) && err_q;
    assign bus.resp_mesi_state = mesi_q;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_req (
        .clk(clk), .clear_i(reset), .inc_i(inc_req), .count_o(stat_requests)
    );
    sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_rty (
        .clk(clk), .clear_i(reset), .inc_i(inc_rty), .count_o(stat_retries)
    );
    sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_err (
        .clk(clk), .clear_i(reset), .inc_i(inc_err), .count_o(stat_errors)
    );

endmodule

// File: tb/tb_l2_coherence_requester.sv
// Bench for l2_coherence_requester: vector table plus hand sequences,
// with a response scoreboard and a small arbiter model.
module tb_l2_coherence_requester;
    import cache_config::*;

    localparam int T = 4;
    localparam int M = 2;
    localparam int CW = 16;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  st;
        int          hold;
        logic        silent;
        logic [1:0]  exp_st;
        logic        exp_err;
        int          lat;
        int          rd;
        int          wrc;
        int          ack;
        int          gap;
    } vec_t;

    typedef struct {
        logic [1:0] st;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [CW-1:0] stat_requests, stat_retries, stat_errors;

    l2_coherence_requester_if itf ();

    l2_coherence_requester #(
        .TIMEOUT_CYCLES(T), .MAX_RETRIES(M), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .bus(itf),
        .stat_requests(stat_requests),
        .stat_retries(stat_retries),
        .stat_errors(stat_errors)
    );

    always #5 clk = ~clk;

    int   pass_cnt = 0;
    int   chk_cnt  = 0;
    int   viol     = 0;
    exp_t sb[$];

    // Arbiter model: combinational verify, optionally held after ack.
    logic       arb_en;
    logic [1:0] arb_state;
    int         hold_n;
    int         hold_cnt;

    logic rd_l, wr_l, ack_l;
    assign rd_l  = itf.arbiter_read_update_from_L2_cache_modules;
    assign wr_l  = itf.arbiter_write_update_from_L2_cache_modules;
    assign ack_l = itf.acknowledge_arbiter_verify;

    always_comb begin
        itf.mesi_state_to_cache = arb_state;
        itf.arbiter_verify = arb_en && (rd_l || wr_l || (ack_l && (hold_cnt < hold_n)));
    end

    always @(posedge clk) hold_cnt <= ack_l ? hold_cnt + 1 : 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if ((rd_l && wr_l) || (ack_l && (rd_l || wr_l))) viol++;
        if (!reset && itf.resp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 64'(1), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_state", 64'(itf.resp_mesi_state), 64'(e.st));
                chk("resp_error", 64'(itf.resp_error), 64'(e.err));
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 40; i++) begin
            if (itf.req_ready) return;
            @(negedge clk);
        end
        chk("ready_timeout", 64'(0), 64'(1));
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   lat, rd, wrc, ack, gap;
        logic held;
        exp_t e;
        arb_state = v.st;
        hold_n    = v.hold;
        arb_en    = !v.silent;
        wait_ready();
        itf.req_valid    = 1'b1;
        itf.req_is_write = v.wr;
        itf.req_address  = v.addr;
        itf.req_data     = v.data;
        e.st  = v.exp_st;
        e.err = v.exp_err;
        sb.push_back(e);
        lat = 0; rd = 0; wrc = 0; ack = 0; gap = 0; held = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) itf.req_valid = 1'b0;
            if (rd_l) rd++;
            if (wr_l) wrc++;
            if (ack_l) ack++;
            if (!itf.req_ready && !rd_l && !wr_l && !ack_l && !itf.resp_valid) gap++;
            if ((rd_l || wr_l) &&
                (itf.block_to_determine_mesi_state_from_arbiter != v.addr ||
                 itf.l2_local_data != v.data)) held = 1'b0;
            if (itf.resp_valid) begin
                lat = c;
                break;
            end
        end
        chk({tag, "_latency"}, 64'(lat), 64'(v.lat));
        chk({tag, "_rd_cycles"}, 64'(rd), 64'(v.rd));
        chk({tag, "_wr_cycles"}, 64'(wrc), 64'(v.wrc));
        chk({tag, "_ack_cycles"}, 64'(ack), 64'(v.ack));
        chk({tag, "_gap_cycles"}, 64'(gap), 64'(v.gap));
        chk({tag, "_addr_data_held"}, 64'(held), 64'(1));
        @(negedge clk);
        chk({tag, "_single_pulse"}, 64'(itf.resp_valid), 64'(0));
    endtask

    vec_t vecs[6];

    initial begin
        logic [6:0] rdy_v, rsp_v;
        exp_t e;
        int   n;
        vecs[0] = '{1'b0, 32'h1A4, 32'h11111111, 2'd2, 0, 1'b0, 2'd2, 1'b0, 3, 1, 0, 1, 0};
        vecs[1] = '{1'b1, 32'h2B0, 32'hDEADBEEF, 2'd3, 0, 1'b0, 2'd3, 1'b0, 3, 0, 1, 1, 0};
        vecs[2] = '{1'b0, 32'h3C8, 32'hCAFEF00D, 2'd1, 2, 1'b0, 2'd1, 1'b0, 5, 1, 0, 3, 0};
        vecs[3] = '{1'b1, 32'h040, 32'h00000000, 2'd0, 0, 1'b0, 2'd0, 1'b0, 3, 0, 1, 1, 0};
        vecs[4] = '{1'b0, 32'h5E0, 32'h12345678, 2'd3, 0, 1'b1, 2'd0, 1'b1,
                    1 + (T + 1) * M, T * M, 0, 0, M};
        vecs[5] = '{1'b1, 32'h7F8, 32'hA5A5A5A5, 2'd3, 1, 1'b0, 2'd3, 1'b0, 4, 0, 1, 2, 0};

        arb_en = 1'b0; arb_state = 2'd0; hold_n = 0;
        itf.req_valid = 1'b0; itf.req_is_write = 1'b0;
        itf.req_address = '0; itf.req_data = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_lines", 64'({rd_l, wr_l, ack_l, itf.resp_valid, itf.resp_error}), 64'(0));
        chk("rst_addr_data", 64'({itf.block_to_determine_mesi_state_from_arbiter,
                                  itf.l2_local_data}), 64'(0));
        chk("rst_stats", 64'({stat_requests, stat_retries, stat_errors}), 64'(0));
        chk("rst_ready", 64'(itf.req_ready), 64'(1));
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_stat_requests", i), 64'(stat_requests), 64'(i + 1));
        end
        chk("stat_retries", 64'(stat_retries), 64'(M));
        chk("stat_errors", 64'(stat_errors), 64'(1));
        chk("sb_empty_table", 64'(sb.size()), 64'(0));

        // req_valid held high: one IDLE cycle between back-to-back transactions
        arb_en = 1'b1; arb_state = 2'd1; hold_n = 0;
        wait_ready();
        itf.req_valid = 1'b1; itf.req_is_write = 1'b0;
        itf.req_address = 32'h100; itf.req_data = 32'h55;
        e.st = 2'd1; e.err = 1'b0;
        sb.push_back(e);
        sb.push_back(e);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            rdy_v[k] = itf.req_ready;
            rsp_v[k] = itf.resp_valid;
        end
        itf.req_valid = 1'b0;
        chk("b2b_ready_pattern", 64'(rdy_v), 64'(7'b0001000));
        chk("b2b_resp_pattern", 64'(rsp_v), 64'(7'b1000100));
        @(negedge clk);
        chk("sb_empty_b2b", 64'(sb.size()), 64'(0));

        // reset asserted while in ACK
        arb_en = 1'b1; arb_state = 2'd2; hold_n = 10;
        wait_ready();
        itf.req_valid = 1'b1; itf.req_is_write = 1'b1;
        itf.req_address = 32'h9A0; itf.req_data = 32'hFACE;
        n = 0;
        for (int c = 0; c < 10 && !ack_l; c++) begin
            @(negedge clk);
            itf.req_valid = 1'b0;
            n++;
        end
        chk("mid_ack_reached", 64'(ack_l), 64'(1));
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_lines", 64'({rd_l, wr_l, ack_l, itf.resp_valid, itf.resp_error}), 64'(0));
        chk("mid_rst_addr_data", 64'({itf.block_to_determine_mesi_state_from_arbiter,
                                      itf.l2_local_data}), 64'(0));
        chk("mid_rst_stats", 64'({stat_requests, stat_retries, stat_errors}), 64'(0));
        chk("mid_rst_ready", 64'(itf.req_ready), 64'(1));
        reset = 1'b0;
        n = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (itf.resp_valid || rd_l || wr_l || ack_l) n++;
        end
        chk("post_rst_quiet", 64'(n), 64'(0));

        run_vec(vecs[0], "recover");
        chk("recover_stat_requests", 64'(stat_requests), 64'(1));
        chk("protocol_violations", 64'(viol), 64'(0));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
